// File: rtl/ram_bank_array_2port.sv
// ram_bank_array_2port: NUM_BANKS simple dual-port RAM banks behind one shared
// write port and one shared read port. Adds write-first forwarding on
// same-cycle address collisions, sticky per-bank "written" flags and a
// read-valid pipeline. OUT_REG selects 0 or 1 extra output register stage.

// One RAM bank: synchronous write, synchronous read (read-before-write).
// Collisions between the two ports are resolved in the top, not here.
module ram_bank_array_2port_bank #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);
  logic [DATA_W-1:0] r_mem [2**ADDR_W];
  logic [DATA_W-1:0] r_q;

  // write port; contents are never reset
  always_ff @(posedge clk)
    if (i_we) r_mem[i_waddr] <= i_wdata;

  // read port; r_q only moves on a read to this bank, so it holds otherwise
  always_ff @(posedge clk)
    if (i_re) r_q <= r_mem[i_raddr];

  assign o_rdata = r_q;
endmodule

module ram_bank_array_2port #(
  parameter int NUM_BANKS = 16,
  parameter int SEL_W     = 4,
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 10,
  parameter int OUT_REG   = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_wr_en,
  input  logic [SEL_W-1:0]     i_wr_sel,
  input  logic [ADDR_W-1:0]    i_wr_addr,
  input  logic [DATA_W-1:0]    i_wr_data,
  input  logic                 i_rd_en,
  input  logic [SEL_W-1:0]     i_rd_sel,
  input  logic [ADDR_W-1:0]    i_rd_addr,
  output logic [DATA_W-1:0]    o_rd_data,
  output logic                 o_rd_valid,
  output logic                 o_rd_err,
  input  logic                 i_clr_en,
  input  logic [SEL_W-1:0]     i_clr_sel,
  output logic [NUM_BANKS-1:0] o_bank_written
);
  localparam int STAGES = 1 + OUT_REG;

  logic [NUM_BANKS-1:0]             w_wr_hit, w_rd_hit, w_clr_hit;
  logic [NUM_BANKS-1:0]             w_wr_we, w_rd_re, w_clr;
  logic [NUM_BANKS-1:0][DATA_W-1:0] w_bank_q;
  logic [NUM_BANKS-1:0]             r_bank_written;
  logic                             w_wr_acc, w_same_bank, w_rd_written;
  logic                             w_req_err, w_coll;

  logic [SEL_W-1:0]                 r_s1_sel;
  logic                             r_s1_coll, r_s1_err;
  logic [DATA_W-1:0]                r_s1_fwd;
  logic [DATA_W-1:0]                w_s1_ram, w_s1_data;

  logic [STAGES:1]                  r_vld_pipe;
  logic [STAGES:0]                  w_vld_pipe;

  // one-hot bank decode; an out-of-range select decodes to all zeros
  always_comb begin
    w_wr_hit  = '0;
    w_rd_hit  = '0;
    w_clr_hit = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      w_wr_hit[b]  = (i_wr_sel  == SEL_W'(b));
      w_rd_hit[b]  = (i_rd_sel  == SEL_W'(b));
      w_clr_hit[b] = (i_clr_sel == SEL_W'(b));
    end
  end

  assign w_wr_we  = w_wr_hit  & {NUM_BANKS{i_wr_en}};
  assign w_rd_re  = w_rd_hit  & {NUM_BANKS{i_rd_en}};
  assign w_clr    = w_clr_hit & {NUM_BANKS{i_clr_en}};
  assign w_wr_acc = |w_wr_we;

  // request-time qualification: the pre-edge written flag counts, and so
  // does a write to the same bank in this very cycle
  assign w_same_bank  = w_wr_acc && (i_wr_sel == i_rd_sel);
  assign w_rd_written = |(w_rd_hit & r_bank_written);
  assign w_req_err    = !(|w_rd_hit) || !(w_rd_written || w_same_bank);
  assign w_coll       = w_same_bank && (i_wr_addr == i_rd_addr);

  genvar g;
  for (g = 0; g < NUM_BANKS; g++) begin : g_bank
    ram_bank_array_2port_bank #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
    ) u_bank (
      .clk     (clk),
      .i_we    (w_wr_we[g]),
      .i_waddr (i_wr_addr),
      .i_wdata (i_wr_data),
      .i_re    (w_rd_re[g]),
      .i_raddr (i_rd_addr),
      .o_rdata (w_bank_q[g])
    );
  end

  // sticky written flags; a write beats a clear of the same bank
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_bank_written <= '0;
    else        r_bank_written <= (r_bank_written & ~w_clr) | w_wr_we;

  assign o_bank_written = r_bank_written;

  // capture the request alongside the RAM read; only updated on a read so the
  // output mux (and therefore rd_data with OUT_REG=0) holds between reads.
  // Reset forces the error path so rd_data reads as zero.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_s1_sel  <= '0;
      r_s1_coll <= 1'b0;
      r_s1_fwd  <= '0;
      r_s1_err  <= 1'b1;
    end else if (i_rd_en) begin
      r_s1_sel  <= i_rd_sel;
      r_s1_coll <= w_coll;
      r_s1_fwd  <= i_wr_data;
      r_s1_err  <= w_req_err;
    end

  // read-valid shift register; reset drops anything in flight
  assign w_vld_pipe = {r_vld_pipe, i_rd_en};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_vld_pipe <= '0;
    else        r_vld_pipe <= w_vld_pipe[STAGES-1:0];

  // bank output mux driven by the registered select
  always_comb begin
    w_s1_ram = '0;
    for (int b = 0; b < NUM_BANKS; b++)
      if (r_s1_sel == SEL_W'(b)) w_s1_ram = w_bank_q[b];
  end

  assign w_s1_data = r_s1_err ? '0 : (r_s1_coll ? r_s1_fwd : w_s1_ram);

  if (OUT_REG != 0) begin : g_oreg
    logic [DATA_W-1:0] r_out_data;
    logic              r_out_err;

    // output register, loaded only when a read leaves stage 1
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        r_out_data <= '0;
        r_out_err  <= 1'b0;
      end else if (r_vld_pipe[1]) begin
        r_out_data <= w_s1_data;
        r_out_err  <= r_s1_err;
      end

    assign o_rd_data = r_out_data;
    assign o_rd_err  = r_vld_pipe[STAGES] & r_out_err;
  end else begin : g_noreg
    assign o_rd_data = w_s1_data;
    assign o_rd_err  = r_vld_pipe[1] & r_s1_err;
  end

  assign o_rd_valid = r_vld_pipe[STAGES];
endmodule

// File: tb/tb_ram_bank_array_2port.sv
// Bench: two instances share one stimulus stream. DUT A uses the default
// parameters; DUT B has NUM_BANKS=5, SEL_W=3, OUT_REG=0 and sees the low
// three bits of every select. A plain array model predicts each read at
// issue time into a queue; a monitor pops and compares on rd_valid.
module tb_ram_bank_array_2port;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_en, rd_en, clr_en;
  logic [3:0] wr_sel, rd_sel, clr_sel;
  logic [9:0] wr_addr, rd_addr;
  logic [7:0] wr_data;

  logic [7:0]  a_rd_data, b_rd_data;
  logic        a_rd_valid, b_rd_valid, a_rd_err, b_rd_err;
  logic [15:0] a_bank_written;
  logic [4:0]  b_bank_written;

  always #5 clk = ~clk;

  ram_bank_array_2port u_dut_a (
    .clk(clk), .rst_n(rst_n),
    .i_wr_en(wr_en), .i_wr_sel(wr_sel), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
    .i_rd_en(rd_en), .i_rd_sel(rd_sel), .i_rd_addr(rd_addr),
    .o_rd_data(a_rd_data), .o_rd_valid(a_rd_valid), .o_rd_err(a_rd_err),
    .i_clr_en(clr_en), .i_clr_sel(clr_sel), .o_bank_written(a_bank_written));

  ram_bank_array_2port #(.NUM_BANKS(5), .SEL_W(3), .DATA_W(8), .ADDR_W(10), .OUT_REG(0)) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .i_wr_en(wr_en), .i_wr_sel(wr_sel[2:0]), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
    .i_rd_en(rd_en), .i_rd_sel(rd_sel[2:0]), .i_rd_addr(rd_addr),
    .o_rd_data(b_rd_data), .o_rd_valid(b_rd_valid), .o_rd_err(b_rd_err),
    .i_clr_en(clr_en), .i_clr_sel(clr_sel[2:0]), .o_bank_written(b_bank_written));

  typedef struct {
    bit       err;
    bit [7:0] data;
    bit       known;
    int       cyc;
  } exp_t;

  exp_t     qa[$], qb[$];
  bit [7:0] mmem   [2][16][1024];
  bit       mknown [2][16][1024];
  bit       mwr    [2][16];
  int       nb  [2] = '{16, 5};
  int       lat [2] = '{2, 1};
  bit [7:0] last_data  [2];
  bit       last_known [2];
  int       cyc = 0;
  int       nchk = 0;
  int       nerr = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int bsel(input int d, input bit [3:0] s);
    return (d == 0) ? int'(s) : int'(s[2:0]);
  endfunction

  task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s dut%0d: got %0h expected %0h (t=%0t)", nm, d, act, exp, $time);
    end
  endtask

  // one clock of stimulus: predict reads from pre-edge model state, then
  // apply writes and clears to the model at the edge (set beats clear)
  task automatic step(input bit we, input bit [3:0] ws, input bit [9:0] wa, input bit [7:0] wd,
                      input bit re, input bit [3:0] rs, input bit [9:0] ra,
                      input bit ce, input bit [3:0] cs);
    @(negedge clk);
    wr_en = we; wr_sel = ws; wr_addr = wa; wr_data = wd;
    rd_en = re; rd_sel = rs; rd_addr = ra;
    clr_en = ce; clr_sel = cs;
    if (re) begin
      for (int d = 0; d < 2; d++) begin
        int   r, w;
        bit   wacc, coll;
        exp_t e;
        r    = bsel(d, rs);
        w    = bsel(d, ws);
        wacc = we && (w < nb[d]);
        coll = wacc && (w == r) && (wa == ra);
        e.cyc = cyc;
        e.err = (r >= nb[d]) || !(mwr[d][r] || (wacc && w == r));
        if (e.err)     begin e.data = 8'h00; e.known = 1'b1; end
        else if (coll) begin e.data = wd;    e.known = 1'b1; end
        else begin e.data = mmem[d][r][ra]; e.known = mknown[d][r][ra]; end
        if (d == 0) qa.push_back(e); else qb.push_back(e);
      end
    end
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      int c, w;
      c = bsel(d, cs);
      w = bsel(d, ws);
      if (ce && c < nb[d]) mwr[d][c] = 1'b0;
      if (we && w < nb[d]) begin
        mmem[d][w][wa]   = wd;
        mknown[d][w][wa] = 1'b1;
        mwr[d][w]        = 1'b1;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // per-cycle output check for one instance
  task automatic mon(input int d, input logic v, input logic er, input logic [7:0] dt,
                     input logic [15:0] bw);
    exp_t      e;
    bit        empty;
    bit [15:0] ebw;
    if (v) begin
      empty = (d == 0) ? (qa.size() == 0) : (qb.size() == 0);
      if (empty) begin
        nchk++; nerr++;
        $display("FAIL spurious_valid dut%0d: got rd_valid=1 expected no read in flight", d);
      end else begin
        if (d == 0) e = qa.pop_front(); else e = qb.pop_front();
        chk("latency", d, cyc - e.cyc, lat[d]);
        chk("rd_err", d, {31'b0, er}, {31'b0, e.err});
        if (e.known) chk("rd_data", d, {24'b0, dt}, {24'b0, e.data});
        last_data[d]  = e.data;
        last_known[d] = e.known;
      end
    end else begin
      chk("rd_err_idle", d, {31'b0, er}, 0);
      if (last_known[d]) chk("rd_data_hold", d, {24'b0, dt}, {24'b0, last_data[d]});
    end
    ebw = '0;
    for (int b = 0; b < nb[d]; b++) ebw[b] = mwr[d][b];
    chk("bank_written", d, {16'b0, bw}, {16'b0, ebw});
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (!rst_n) begin
        chk("valid_in_reset", 0, {31'b0, a_rd_valid}, 0);
        chk("valid_in_reset", 1, {31'b0, b_rd_valid}, 0);
      end else begin
        mon(0, a_rd_valid, a_rd_err, a_rd_data, a_bank_written);
        mon(1, b_rd_valid, b_rd_err, b_rd_data, {11'b0, b_bank_written});
      end
    end
  end

  task automatic reset_model();
    qa.delete();
    qb.delete();
    for (int d = 0; d < 2; d++) begin
      for (int b = 0; b < 16; b++) mwr[d][b] = 1'b0;
      last_data[d]  = 8'h00;
      last_known[d] = 1'b1;
    end
  endtask

  task automatic reset_checks();
    chk("reset_rd_data", 0, {24'b0, a_rd_data}, 0);
    chk("reset_rd_data", 1, {24'b0, b_rd_data}, 0);
    chk("reset_rd_err", 0, {31'b0, a_rd_err}, 0);
    chk("reset_rd_err", 1, {31'b0, b_rd_err}, 0);
    chk("reset_bank_written", 0, {16'b0, a_bank_written}, 0);
    chk("reset_bank_written", 1, {27'b0, b_bank_written}, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    wr_en = 0; wr_sel = 0; wr_addr = 0; wr_data = 0;
    rd_en = 0; rd_sel = 0; rd_addr = 0; clr_en = 0; clr_sel = 0;
    reset_model();
    repeat (3) @(posedge clk);
    #2;
    reset_checks();
    @(negedge clk);
    rst_n = 1'b1;

    // basic read-back
    step(1, 3, 10'h010, 8'hA5, 0, 0, 0, 0, 0);
    idle(1);
    step(0, 0, 0, 0, 1, 3, 10'h010, 0, 0);
    idle(3);

    // bank isolation (sel 15 is out of range for B)
    step(1, 0, 10'd5, 8'h11, 0, 0, 0, 0, 0);
    step(1, 15, 10'd5, 8'h22, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 10'd5, 0, 0);
    step(0, 0, 0, 0, 1, 15, 10'd5, 0, 0);
    step(0, 0, 0, 0, 1, 7, 10'd5, 0, 0);
    idle(3);

    // collision forwarding
    step(1, 2, 10'h3FF, 8'h0F, 0, 0, 0, 0, 0);
    step(1, 2, 10'h3FF, 8'hF0, 1, 2, 10'h3FF, 0, 0);
    step(0, 0, 0, 0, 1, 2, 10'h3FF, 0, 0);
    idle(3);

    // clear, error on read, then clear/write race
    step(1, 4, 10'd0, 8'h55, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 4);
    step(0, 0, 0, 0, 1, 4, 10'd0, 0, 0);
    step(1, 4, 10'd1, 8'h66, 0, 0, 0, 1, 4);
    step(0, 0, 0, 0, 1, 4, 10'd0, 0, 0);
    idle(3);

    // select 6: real bank in A, dropped write / error read in B
    step(1, 6, 10'd7, 8'h77, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 6, 10'd7, 0, 0);
    idle(3);

    // randomized traffic, biased toward collisions and a small address pool
    for (int i = 0; i < 600; i++) begin
      bit [3:0] ws, rs, cs;
      bit [9:0] wa, ra;
      ws = 4'($urandom_range(0, 15));
      wa = ($urandom_range(0, 7) == 0) ? 10'h3FF : 10'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) begin rs = ws; ra = wa; end
      else begin
        rs = 4'($urandom_range(0, 15));
        ra = ($urandom_range(0, 7) == 0) ? 10'h3FF : 10'($urandom_range(0, 7));
      end
      cs = 4'($urandom_range(0, 15));
      step(1'($urandom_range(0, 1)), ws, wa, 8'($urandom),
           1'($urandom_range(0, 1)), rs, ra,
           ($urandom_range(0, 7) == 0), cs);
    end
    idle(3);

    // reset while a read is in flight
    step(1, 9, 10'd20, 8'h99, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 9, 10'd20, 0, 0);
    @(negedge clk);
    rst_n = 1'b0;
    wr_en = 0; rd_en = 0; clr_en = 0;
    reset_model();
    #1;
    reset_checks();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle(2);
    // re-mark the bank with a different address, then read retained data
    step(1, 9, 10'd21, 8'h12, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 9, 10'd20, 0, 0);
    idle(4);

    chk("queue_drained", 0, qa.size(), 0);
    chk("queue_drained", 1, qb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule

// File: doc/ram_bank_array_2port.md
# ram_bank_array_2port

Parametrised bank array of simple dual-port RAMs sharing one write port and one read port, each steered by a bank-select field. It is the general successor of the fixed 16×1K×8 source buffer: bank count, data width, depth and output registering are parameters. It adds three things the fixed buffer lacks: a read-valid pipeline, write-first forwarding on same-cycle address collisions, and per-bank "written" tracking with an error flag. It sits between the sample-capture writer and the processing-side reader in the FPGA datapath.

## Interface
- NUM_BANKS, 16, number of RAM banks (2..64)
- SEL_W, 4, bank-select width; must satisfy 2^SEL_W ≥ NUM_BANKS
- DATA_W, 8, word width
- ADDR_W, 10, per-bank address width; depth = 2^ADDR_W
- OUT_REG, 1, 1 = extra output register stage; 0 = none

- clk  in  1  sole clock, all logic rising-edge
- rst_n  in  1  asynchronous active-low reset
- wr_en  in  1  write strobe
- wr_sel  in  SEL_W  write bank index
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- rd_en  in  1  read request
- rd_sel  in  SEL_W  read bank index
- rd_addr  in  ADDR_W  read address
- rd_data  out  DATA_W  read data, valid when rd_valid=1
- rd_valid  out  1  one-cycle pulse per accepted read
- rd_err  out  1  qualifies rd_valid: bank out of range or never written
- clr_en  in  1  clear the written flag of bank clr_sel
- clr_sel  in  SEL_W  bank to clear
- bank_written  out  NUM_BANKS  sticky per-bank "written since clear" flags

## Operation
- One clock domain, clk. Reset is asynchronous and active-low (rst_n).
- **Write:** when wr_en=1 and wr_sel<NUM_BANKS, wr_data is written to bank[wr_sel][wr_addr] at the clock edge. Only that bank's write enable asserts.
  - If wr_sel≥NUM_BANKS, the write is dropped with no side effects.
- **Read:** when rd_en=1, bank[rd_sel] is read synchronously at rd_addr. Only that bank's read enable asserts.
  - rd_sel is registered alongside the read and drives the output mux.
  - The result passes through OUT_REG optional stages.
- **Forwarding (write-first):** when rd_en and wr_en are both 1 with rd_sel==wr_sel and rd_addr==wr_addr (sel in range), rd_data returns wr_data, not the old contents.
  - This is implemented by a registered collision flag plus a captured data word.
- **Written tracking:** bank_written[wr_sel] sets on every accepted write. clr_en clears bank_written[clr_sel].
  - If clr and write hit the same bank in the same cycle, set wins.
  - If clr_sel≥NUM_BANKS, the clear is ignored.
- **Error:** rd_err=1 with rd_valid when, at request time, rd_sel≥NUM_BANKS, or bank_written[rd_sel]=0 and no same-cycle write to that bank.
  - On error, rd_data=0.
- **Holding:** rd_data holds its last value while rd_valid=0.
  - rd_valid and rd_err are 0 whenever no read completes.
- No backpressure: the read port accepts one request every cycle.

## Timing
- Read latency is 1+OUT_REG cycles from rd_en sampled to rd_valid/rd_data: 2 cycles at the default setting, 1 with OUT_REG=0.
- Back-to-back reads give back-to-back rd_valid pulses, in request order.
- A write at edge N is visible to a non-colliding read requested at edge N+1. A read at the same edge N to the same location is forwarded.
- bank_written updates one cycle after the write or clear edge. The error check uses the pre-edge flag ORed with a same-cycle matching write.
- **Reset values:**
  - rd_data=0, rd_valid=0, rd_err=0
  - bank_written=0
  - all pipeline valid bits cleared
  - RAM contents are not reset and are retained across rst_n.
- **Reset mid-operation:** in-flight reads are discarded, so no rd_valid is produced for requests issued before or during reset.
- rd_en and wr_en are fully independent and may target any banks concurrently.

## Test plan
- **Basic read-back:** write 0xA5 to bank 3 addr 0x010, later read bank 3 addr 0x010 → rd_valid exactly 2 cycles later, rd_data=0xA5, rd_err=0, bank_written=16'h0008.
- **Bank isolation:** write 0x11 to bank 0 addr 5 and 0x22 to bank 15 addr 5. Read both back-to-back → consecutive rd_valid pulses with 0x11 then 0x22. Bank 7 addr 5 read → rd_err=1, rd_data=0.
- **Collision:** bank 2 addr 0x3FF holds 0x0F; same cycle wr 0xF0 and rd bank 2 addr 0x3FF → rd_data=0xF0. Next read of the same location → 0xF0.
- **Clear/set race:** bank 4 written. Pulse clr_en with clr_sel=4 → bank_written[4]=0, and a subsequent read flags rd_err. Then clr_en and wr_en to bank 4 in the same cycle → bank_written[4]=1.
- **Parameter sweep:** NUM_BANKS=5, OUT_REG=0 → write to sel 6 dropped, read of sel 6 returns rd_err=1 after 1 cycle, and read latency is 1.
- **Reset mid-read:** issue rd_en, assert rst_n=0 on the following cycle → rd_valid never pulses. After release, earlier written data still reads back correctly.
